id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 16-bit pipelined CPU, directly upstream of the ALU. It registers decoded operands and controls from ID and resolves data forwarding from EX/MEM and MEM/WB. It drives the ALU's A, B and FuncCode inputs, and it flags load-use hazards back to the hazard controller. Stall holds the stage; flush inserts a bubble.

## Interface
- WIDTH, 16, datapath width
- RADDR, 2, register-address width (4 GPRs, all forwardable, no hard-wired zero)
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid, in_use_rs1, in_use_rs2, in_use_imm, in_reg_write, in_mem_read, in_is_branch  in  1 each  decoded ID controls
- in_rs1, in_rs2, in_rd  in  RADDR each  register addresses
- in_rs1_data, in_rs2_data, in_imm  in  WIDTH each  register-file reads, sign-extended immediate
- in_func  in  4  ALU FuncCode
- stall  in  1  hold stage contents
- flush  in  1  replace next contents with bubble
- exmem_valid, exmem_reg_write  in  1 each; exmem_rd  in  RADDR; exmem_data  in  WIDTH  EX/MEM producer
- memwb_valid, memwb_reg_write  in  1 each; memwb_rd  in  RADDR; memwb_data  in  WIDTH  MEM/WB producer
- alu_a, alu_b  out  WIDTH  forwarded ALU operands
- alu_func  out  4  registered FuncCode
- ex_valid, ex_reg_write, ex_mem_read, ex_is_branch  out  1 each  registered controls
- ex_rd  out  RADDR  registered destination
- load_use_hazard  out  1  combinational hazard flag to ID

## Operation
- Register set: valid, rs1/rs2 addrs, use_rs1/use_rs2/use_imm, op1/op2 data, imm, func, rd, reg_write, mem_read, is_branch.
- Per-edge priority: reset > flush > stall > load.
- Reset: all regs 0, except func = 4'b1111 (ALU zero op).
- Flush: bubble. valid, reg_write, mem_read and is_branch = 0. func = 4'b1111. Data and address fields are zeroed.
- Load (no stall, no flush): capture all in_* fields.
- Stall: control fields hold. op1/op2 reload with the current forwarded values fwd1/fwd2. A producer that retires during the stall therefore is not lost.
- Forwarding for operand n (n = 1, 2), with src = rsn:
  - EX/MEM match when exmem_valid & exmem_reg_write & exmem_rd == src → exmem_data.
  - Else MEM/WB match (same test on memwb_*) → memwb_data.
  - Else registered opn.
  - Forwarding applies only when use_rsn = 1.
- Outputs:
  - alu_a = fwd1.
  - alu_b = use_imm ? imm : fwd2.
  - alu_func = func. When valid = 0, alu_func is 4'b1111.
- load_use_hazard = ex_valid & ex_mem_read & ex_reg_write & in_valid & ((in_use_rs1 & in_rs1 == ex_rd) | (in_use_rs2 & in_rs2 == ex_rd)). The block never acts on this flag itself. The controller responds by stalling IF/ID and pulsing flush here.
- Width rules: no arithmetic in this block. All data is passed bit-exact at WIDTH.

## Timing
- Latency: ID inputs at edge k appear on ex_* and alu_* after edge k.
- Forwarding path is combinational from exmem_*/memwb_* to alu_a/alu_b in the same cycle.
- Flush during stall: bubble (flush wins).
- Stall held for N cycles: stage contents are constant except op1/op2 refresh. ex_valid does not toggle.
- Reset asserted mid-stream: after the edge, ex_valid = 0 and alu_func = 4'b1111 regardless of stall/flush.
- EX/MEM and MEM/WB both match the same register: EX/MEM (youngest) wins.
- Producer with valid = 0 or reg_write = 0 never forwards.

## Structure
- Shared package cpu_pkg:
  - WIDTH and RADDR.
  - FuncCode constants FUNC_ADD = 0, FUNC_SUB = 1, FUNC_ID_A = 2, FUNC_NOT = 3, FUNC_AND = 4, FUNC_OR = 5, FUNC_BNE = 6, FUNC_BEQ = 7, FUNC_BGZ = 8, FUNC_BLZ = 9, FUNC_ID_B = 10, FUNC_SHL = 12, FUNC_SHR = 13, FUNC_TCP = 14, FUNC_ZERO = 15.
- Sub-module fwd_mux: one instance per operand (src, use, registered data, both producer buses → forwarded value).

## Test plan
- Load then idle: load rs1_data = 16'h0005, rs2_data = 16'h0003, func = 0 → next cycle alu_a = 5, alu_b = 3, alu_func = 0, ex_valid = 1.
- Priority: rs1 = 2; exmem rd = 2 with data 16'hAAAA; memwb rd = 2 with data 16'h5555 → alu_a = 16'hAAAA. Deassert exmem_reg_write → alu_a = 16'h5555.
- Stall refresh: stalled with op1 forwarded from memwb (16'h1234); next cycle memwb idle, stall held → alu_a stays 16'h1234.
- Load-use: ex_mem_read = 1, ex_rd = 1; in_rs2 = 1, in_use_rs2 = 1 → load_use_hazard = 1. Same with in_use_rs2 = 0 → 0.
- Flush + stall on the same edge → ex_valid = 0, ex_reg_write = 0, alu_func = 4'b1111.
- Reset mid-stream with stall = 1 → all ex_* = 0, alu_func = 4'b1111; use_imm = 1 with imm = 16'hFFFE → alu_b = 16'hFFFE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: widths, ALU FuncCodes and
// the ID/EX stage register layout.
package cpu_pkg;

    localparam int WIDTH = 16;
    localparam int RADDR = 2;

    localparam logic [3:0] FUNC_ADD  = 4'd0;
    localparam logic [3:0] FUNC_SUB  = 4'd1;
    localparam logic [3:0] FUNC_ID_A = 4'd2;
    localparam logic [3:0] FUNC_NOT  = 4'd3;
    localparam logic [3:0] FUNC_AND  = 4'd4;
    localparam logic [3:0] FUNC_OR   = 4'd5;
    localparam logic [3:0] FUNC_BNE  = 4'd6;
    localparam logic [3:0] FUNC_BEQ  = 4'd7;
    localparam logic [3:0] FUNC_BGZ  = 4'd8;
    localparam logic [3:0] FUNC_BLZ  = 4'd9;
    localparam logic [3:0] FUNC_ID_B = 4'd10;
    localparam logic [3:0] FUNC_SHL  = 4'd12;
    localparam logic [3:0] FUNC_SHR  = 4'd13;
    localparam logic [3:0] FUNC_TCP  = 4'd14;
    localparam logic [3:0] FUNC_ZERO = 4'd15;

    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
        logic             use_imm;
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
        logic [WIDTH-1:0] imm;
        logic [3:0]       func;
        logic [RADDR-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             is_branch;
    } idex_t;

    // Reset and flush both leave the stage holding this bubble.
    function automatic idex_t idex_bubble();
        idex_t b;
        b      = '0;
        b.func = FUNC_ZERO;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM result, else MEM/WB result, else the
// value captured in the ID/EX register.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RADDR-1:0] i_src,
    input  logic             i_use,
    input  logic [WIDTH-1:0] i_reg_data,
    input  logic             i_exmem_valid,
    input  logic             i_exmem_reg_write,
    input  logic [RADDR-1:0] i_exmem_rd,
    input  logic [WIDTH-1:0] i_exmem_data,
    input  logic             i_memwb_valid,
    input  logic             i_memwb_reg_write,
    input  logic [RADDR-1:0] i_memwb_rd,
    input  logic [WIDTH-1:0] i_memwb_data,
    output logic [WIDTH-1:0] o_fwd
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_use & i_exmem_valid & i_exmem_reg_write & (i_exmem_rd == i_src);
    assign w_memwb_hit = i_use & i_memwb_valid & i_memwb_reg_write & (i_memwb_rd == i_src);

    // EX/MEM is the younger producer, so it takes priority.
    always_comb begin
        o_fwd = i_reg_data;
        if (w_exmem_hit)
            o_fwd = i_exmem_data;
        else if (w_memwb_hit)
            o_fwd = i_memwb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection for the hazard controller.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic             in_use_imm,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic             in_is_branch,
    input  logic [RADDR-1:0] in_rs1,
    input  logic [RADDR-1:0] in_rs2,
    input  logic [RADDR-1:0] in_rd,
    input  logic [WIDTH-1:0] in_rs1_data,
    input  logic [WIDTH-1:0] in_rs2_data,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [3:0]       in_func,
    input  logic             stall,
    input  logic             flush,
    input  logic             exmem_valid,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_data,
    input  logic             memwb_valid,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_func,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_is_branch,
    output logic [RADDR-1:0] ex_rd,
    output logic             load_use_hazard
);

    idex_t            r_stage;
    logic [WIDTH-1:0] w_fwd1;
    logic [WIDTH-1:0] w_fwd2;
    logic             w_rs1_dep;
    logic             w_rs2_dep;

    fwd_mux u_fwd1 (
        .i_src             (r_stage.rs1),
        .i_use             (r_stage.use_rs1),
        .i_reg_data        (r_stage.op1),
        .i_exmem_valid     (exmem_valid),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_data      (exmem_data),
        .i_memwb_valid     (memwb_valid),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_data      (memwb_data),
        .o_fwd             (w_fwd1)
    );

    fwd_mux u_fwd2 (
        .i_src             (r_stage.rs2),
        .i_use             (r_stage.use_rs2),
        .i_reg_data        (r_stage.op2),
        .i_exmem_valid     (exmem_valid),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_data      (exmem_data),
        .i_memwb_valid     (memwb_valid),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_data      (memwb_data),
        .o_fwd             (w_fwd2)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_stage <= idex_bubble();
        end else if (stall) begin
            // Re-capture forwarded operands so a producer retiring mid-stall is kept.
            r_stage.op1 <= w_fwd1;
            r_stage.op2 <= w_fwd2;
        end else begin
            r_stage.valid     <= in_valid;
            r_stage.rs1       <= in_rs1;
            r_stage.rs2       <= in_rs2;
            r_stage.use_rs1   <= in_use_rs1;
            r_stage.use_rs2   <= in_use_rs2;
            r_stage.use_imm   <= in_use_imm;
            r_stage.op1       <= in_rs1_data;
            r_stage.op2       <= in_rs2_data;
            r_stage.imm       <= in_imm;
            r_stage.func      <= in_func;
            r_stage.rd        <= in_rd;
            r_stage.reg_write <= in_reg_write;
            r_stage.mem_read  <= in_mem_read;
            r_stage.is_branch <= in_is_branch;
        end
    end

    assign alu_a    = w_fwd1;
    assign alu_b    = r_stage.use_imm ? r_stage.imm : w_fwd2;
    assign alu_func = r_stage.valid ? r_stage.func : FUNC_ZERO;

    assign ex_valid     = r_stage.valid;
    assign ex_reg_write = r_stage.reg_write;
    assign ex_mem_read  = r_stage.mem_read;
    assign ex_is_branch = r_stage.is_branch;
    assign ex_rd        = r_stage.rd;

    assign w_rs1_dep = in_use_rs1 & (in_rs1 == r_stage.rd);
    assign w_rs2_dep = in_use_rs2 & (in_rs2 == r_stage.rd);

    assign load_use_hazard = r_stage.valid & r_stage.mem_read & r_stage.reg_write
                           & in_valid & (w_rs1_dep | w_rs2_dep);

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: forwarding vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_use_rs1, in_use_rs2, in_use_imm;
    logic             in_reg_write, in_mem_read, in_is_branch;
    logic [RADDR-1:0] in_rs1, in_rs2, in_rd;
    logic [WIDTH-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic [3:0]       in_func;
    logic             stall, flush;
    logic             exmem_valid, exmem_reg_write;
    logic [RADDR-1:0] exmem_rd;
    logic [WIDTH-1:0] exmem_data;
    logic             memwb_valid, memwb_reg_write;
    logic [RADDR-1:0] memwb_rd;
    logic [WIDTH-1:0] memwb_data;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_func;
    logic             ex_valid, ex_reg_write, ex_mem_read, ex_is_branch;
    logic [RADDR-1:0] ex_rd;
    logic             load_use_hazard;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_use_imm(in_use_imm), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_is_branch(in_is_branch), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_func(in_func), .stall(stall), .flush(flush),
        .exmem_valid(exmem_valid), .exmem_reg_write(exmem_reg_write),
        .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_valid(memwb_valid), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_is_branch(ex_is_branch), .ex_rd(ex_rd), .load_use_hazard(load_use_hazard)
    );

    // Reference model: the stage contents as one record of named fields.
    typedef struct {
        bit       valid, use1, use2, useimm, rw, mr, br;
        int       rs1, rs2, rd, func;
        int       op1, op2, imm;
    } model_t;
    model_t m;

    function automatic int forwarded(int src, bit use_it, int held);
        if (!use_it) return held;
        if (exmem_valid && exmem_reg_write && int'(exmem_rd) == src) return int'(exmem_data);
        if (memwb_valid && memwb_reg_write && int'(memwb_rd) == src) return int'(memwb_data);
        return held;
    endfunction

    always @(posedge clk) begin
        int f1, f2;
        f1 = forwarded(m.rs1, m.use1, m.op1);
        f2 = forwarded(m.rs2, m.use2, m.op2);
        if (reset || flush) begin
            m = '{valid:0, use1:0, use2:0, useimm:0, rw:0, mr:0, br:0,
                  rs1:0, rs2:0, rd:0, func:15, op1:0, op2:0, imm:0};
        end else if (stall) begin
            m.op1 = f1;
            m.op2 = f2;
        end else begin
            m = '{valid:in_valid, use1:in_use_rs1, use2:in_use_rs2, useimm:in_use_imm,
                  rw:in_reg_write, mr:in_mem_read, br:in_is_branch,
                  rs1:int'(in_rs1), rs2:int'(in_rs2), rd:int'(in_rd), func:int'(in_func),
                  op1:int'(in_rs1_data), op2:int'(in_rs2_data), imm:int'(in_imm)};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_all();
        in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0; in_use_imm = 0;
        in_reg_write = 0; in_mem_read = 0; in_is_branch = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_func = 0;
        stall = 0; flush = 0;
        exmem_valid = 0; exmem_reg_write = 0; exmem_rd = 0; exmem_data = 0;
        memwb_valid = 0; memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    typedef struct {
        string       name;
        logic        exv, exw;
        logic [1:0]  exrd;
        logic [15:0] exd;
        logic        mwv, mww;
        logic [1:0]  mwrd;
        logic [15:0] mwd;
        logic [15:0] exp_a;
    } fwd_vec_t;

    fwd_vec_t vecs[$];

    initial begin
        // Stage holds rs1 = 2, use_rs1 = 1, op1 = 16'h1111 during the table.
        vecs.push_back('{"both_match_exmem_wins", 1,1,2'd2,16'hAAAA, 1,1,2'd2,16'h5555, 16'hAAAA});
        vecs.push_back('{"exmem_no_write",        1,0,2'd2,16'hAAAA, 1,1,2'd2,16'h5555, 16'h5555});
        vecs.push_back('{"exmem_invalid",         0,1,2'd2,16'hAAAA, 1,1,2'd2,16'h5555, 16'h5555});
        vecs.push_back('{"exmem_rd_mismatch",     1,1,2'd3,16'hAAAA, 1,1,2'd2,16'h5555, 16'h5555});
        vecs.push_back('{"memwb_invalid",         0,0,2'd0,16'h0000, 0,1,2'd2,16'h5555, 16'h1111});
        vecs.push_back('{"memwb_no_write",        0,0,2'd0,16'h0000, 1,0,2'd2,16'h5555, 16'h1111});
        vecs.push_back('{"exmem_only",            1,1,2'd2,16'hBEEF, 0,0,2'd0,16'h0000, 16'hBEEF});
        vecs.push_back('{"no_producer",           0,0,2'd0,16'h0000, 0,0,2'd0,16'h0000, 16'h1111});
        vecs.push_back('{"memwb_rd_mismatch",     0,0,2'd0,16'h0000, 1,1,2'd1,16'h5555, 16'h1111});

        idle_all();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        #1;
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_alu_func", alu_func, 15);
        chk("reset_alu_a", alu_a, 0);

        // Load then idle.
        in_valid = 1; in_use_rs1 = 1; in_use_rs2 = 1; in_rs1 = 0; in_rs2 = 1;
        in_rs1_data = 16'h0005; in_rs2_data = 16'h0003; in_func = FUNC_ADD;
        @(negedge clk); idle_all(); #1;
        chk("load_alu_a", alu_a, 5);
        chk("load_alu_b", alu_b, 3);
        chk("load_alu_func", alu_func, 0);
        chk("load_ex_valid", ex_valid, 1);

        // Forwarding table.
        in_valid = 1; in_use_rs1 = 1; in_rs1 = 2; in_rs1_data = 16'h1111; in_func = FUNC_OR;
        @(negedge clk);
        foreach (vecs[i]) begin
            exmem_valid = vecs[i].exv; exmem_reg_write = vecs[i].exw;
            exmem_rd = vecs[i].exrd; exmem_data = vecs[i].exd;
            memwb_valid = vecs[i].mwv; memwb_reg_write = vecs[i].mww;
            memwb_rd = vecs[i].mwrd; memwb_data = vecs[i].mwd;
            #1 chk(vecs[i].name, alu_a, vecs[i].exp_a);
            exmem_valid = 0; memwb_valid = 0;
            @(negedge clk);
        end

        // Stall refresh: memwb value captured during stall survives its retirement.
        idle_all();
        in_valid = 1; in_use_rs1 = 1; in_rs1 = 1; in_rs1_data = 16'h0000; in_func = FUNC_ADD;
        @(negedge clk);
        stall = 1; memwb_valid = 1; memwb_reg_write = 1; memwb_rd = 1; memwb_data = 16'h1234;
        #1 chk("stall_fwd_now", alu_a, 16'h1234);
        @(negedge clk);
        memwb_valid = 0; memwb_data = 16'h0000;
        #1 chk("stall_refresh_kept", alu_a, 16'h1234);
        chk("stall_ex_valid_held", ex_valid, 1);
        @(negedge clk);
        #1 chk("stall_second_cycle", alu_a, 16'h1234);

        // Load-use hazard.
        idle_all();
        in_valid = 1; in_reg_write = 1; in_mem_read = 1; in_rd = 1; in_func = FUNC_ADD;
        @(negedge clk);
        in_valid = 1; in_mem_read = 0; in_reg_write = 0; in_rd = 0;
        in_use_rs1 = 0; in_rs1 = 3; in_rs2 = 1; in_use_rs2 = 1;
        #1 chk("load_use_hit", load_use_hazard, 1);
        in_use_rs2 = 0;
        #1 chk("load_use_unused", load_use_hazard, 0);
        in_use_rs1 = 1; in_rs1 = 1;
        #1 chk("load_use_rs1", load_use_hazard, 1);

        // Flush and stall on the same edge.
        idle_all();
        in_valid = 1; in_reg_write = 1; in_func = FUNC_SUB; in_rd = 2;
        @(negedge clk);
        idle_all(); flush = 1; stall = 1;
        @(negedge clk);
        flush = 0; stall = 0;
        #1 chk("flush_ex_valid", ex_valid, 0);
        chk("flush_ex_reg_write", ex_reg_write, 0);
        chk("flush_alu_func", alu_func, 15);
        chk("flush_ex_rd", ex_rd, 0);

        // Reset mid-stream with stall held.
        in_valid = 1; in_reg_write = 1; in_mem_read = 1; in_is_branch = 1; in_rd = 3;
        in_func = FUNC_AND; in_use_rs1 = 1; in_rs1_data = 16'h7777;
        @(negedge clk);
        reset = 1; stall = 1;
        @(negedge clk);
        reset = 0; stall = 0;
        #1 chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_reg_write", ex_reg_write, 0);
        chk("rst_ex_mem_read", ex_mem_read, 0);
        chk("rst_ex_is_branch", ex_is_branch, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_alu_func", alu_func, 15);
        chk("rst_alu_a", alu_a, 0);
        idle_all();
        in_valid = 1; in_use_imm = 1; in_imm = 16'hFFFE; in_rs2_data = 16'h1234; in_func = FUNC_ADD;
        @(negedge clk);
        idle_all();
        #1 chk("imm_alu_b", alu_b, 16'hFFFE);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            in_valid = $urandom; in_use_rs1 = $urandom; in_use_rs2 = $urandom;
            in_use_imm = $urandom; in_reg_write = $urandom; in_mem_read = $urandom;
            in_is_branch = $urandom;
            in_rs1 = $urandom; in_rs2 = $urandom; in_rd = $urandom;
            in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
            in_func = $urandom;
            exmem_valid = $urandom; exmem_reg_write = $urandom; exmem_rd = $urandom;
            exmem_data = $urandom;
            memwb_valid = $urandom; memwb_reg_write = $urandom; memwb_rd = $urandom;
            memwb_data = $urandom;
            #1;
            begin
                int e_a, e_b, e_f;
                bit e_haz;
                e_a = forwarded(m.rs1, m.use1, m.op1);
                e_b = m.useimm ? m.imm : forwarded(m.rs2, m.use2, m.op2);
                e_f = m.valid ? m.func : 15;
                e_haz = m.valid && m.mr && m.rw && in_valid &&
                        ((in_use_rs1 && int'(in_rs1) == m.rd) ||
                         (in_use_rs2 && int'(in_rs2) == m.rd));
                chk("rnd_alu_a", alu_a, e_a);
                chk("rnd_alu_b", alu_b, e_b);
                chk("rnd_alu_func", alu_func, e_f);
                chk("rnd_ctrl", {ex_valid, ex_reg_write, ex_mem_read, ex_is_branch},
                    {m.valid, m.rw, m.mr, m.br});
                chk("rnd_ex_rd", ex_rd, m.rd);
                chk("rnd_hazard", load_use_hazard, e_haz);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
